// File: rtl/mod_n_digit_counter_pkg.sv
// Shared types and the next-value function for the stopwatch digit counters.
package mod_n_digit_counter_pkg;

  typedef enum logic {DIR_UP, DIR_DOWN} count_dir_e;

  // Next digit value. An out-of-range q always lands on a legal value:
  // 0 when counting up, modulus-1 when counting down. No 2**WIDTH overflow is assumed.
  function automatic int unsigned next_digit(input int unsigned q,
                                             input count_dir_e  dir,
                                             input int unsigned modulus);
    if (dir == DIR_UP)
      return (q >= modulus - 1) ? 0 : q + 1;
    else
      return (q == 0 || q >= modulus) ? modulus - 1 : q - 1;
  endfunction

endpackage

// File: rtl/mod_n_digit_counter_if.sv
// Control/data bundle of one mod-N digit counter.
// Optional lap capture signals exist only when MOD_N_LAP_EN is defined.
interface mod_n_digit_counter_if #(parameter int WIDTH = 4);
  logic             enable;
  logic             reverse;
  logic             carry_in;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             carry_out;
  logic             wrapped;
`ifdef MOD_N_LAP_EN
  logic             lap;
  logic [WIDTH-1:0] lap_q;

  modport master (output enable, reverse, carry_in, load, load_val, lap,
                  input  q, carry_out, wrapped, lap_q);
  modport slave  (input  enable, reverse, carry_in, load, load_val, lap,
                  output q, carry_out, wrapped, lap_q);
`else
  modport master (output enable, reverse, carry_in, load, load_val,
                  input  q, carry_out, wrapped);
  modport slave  (input  enable, reverse, carry_in, load, load_val,
                  output q, carry_out, wrapped);
`endif
endinterface

// File: rtl/mod_n_digit_counter_step.sv
// Combinational next value and terminal-count detect for a mod-N digit.
module mod_n_digit_counter_step
  import mod_n_digit_counter_pkg::*;
#(
  parameter int MODULUS = 6,
  parameter int WIDTH   = 4
) (
  input  logic [WIDTH-1:0] q,
  input  count_dir_e       dir,
  output logic [WIDTH-1:0] next_q,
  output logic             at_terminal
);

  assign next_q      = WIDTH'(next_digit(32'(q), dir, 32'(MODULUS)));
  assign at_terminal = (dir == DIR_DOWN) ? (q == '0) : (q == WIDTH'(MODULUS - 1));

endmodule

// File: rtl/mod_n_digit_counter.sv
// Cascadable mod-N up/down digit counter with synchronous load and ripple carry.
// Optional feature: define MOD_N_LAP_EN to add a lap snapshot register (bus.lap / bus.lap_q).
module mod_n_digit_counter
  import mod_n_digit_counter_pkg::*;
#(
  parameter int MODULUS = 6,
  parameter int WIDTH   = 4
) (
  input logic                  clk,
  input logic                  reset_n,
  mod_n_digit_counter_if.slave bus
);

  logic [WIDTH-1:0] q_p1;
  logic             wrapped_p1;
  logic [WIDTH-1:0] next_q;
  logic             at_terminal;
  logic             step;
  count_dir_e       dir;

  // Load values beyond the count range saturate to the top digit.
  function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] v);
    return (32'(v) > 32'(MODULUS - 1)) ? WIDTH'(MODULUS - 1) : v;
  endfunction

  assign dir  = bus.reverse ? DIR_DOWN : DIR_UP;
  assign step = bus.enable & bus.carry_in & ~bus.load;

  mod_n_digit_counter_step #(.MODULUS(MODULUS), .WIDTH(WIDTH)) u_step (
    .q           (q_p1),
    .dir         (dir),
    .next_q      (next_q),
    .at_terminal (at_terminal)
  );

  // Stage p0 -> p1: priority reset > load > step > hold; wrap pulse lasts one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_p1       <= '0;
      wrapped_p1 <= 1'b0;
    end else if (bus.load) begin
      q_p1       <= sat_load(bus.load_val);
      wrapped_p1 <= 1'b0;
    end else if (step) begin
      q_p1       <= next_q;
      wrapped_p1 <= at_terminal;
    end else begin
      wrapped_p1 <= 1'b0;
    end
  end

  // Carry is live so a chain of digits advances on the same edge.
  assign bus.carry_out = step & at_terminal;
  assign bus.q         = q_p1;
  assign bus.wrapped   = wrapped_p1;

`ifdef MOD_N_LAP_EN
  logic [WIDTH-1:0] lap_q_p1;

  // Lap snapshot of the pre-update digit, independent of load/step on the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n)
      lap_q_p1 <= '0;
    else if (bus.lap)
      lap_q_p1 <= q_p1;
  end

  assign bus.lap_q = lap_q_p1;
`endif

endmodule

// File: tb/tb_mod_n_digit_counter.sv
// Scoreboard bench for mod_n_digit_counter (MODULUS=6 main instance, MODULUS=10 side instance).
// Lap checks are active when MOD_N_LAP_EN is defined.
module tb_mod_n_digit_counter;
  localparam int M   = 6;
  localparam int M10 = 10;
  localparam int W   = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mod_n_digit_counter_if #(.WIDTH(W)) b ();
  mod_n_digit_counter_if #(.WIDTH(W)) b10 ();

  mod_n_digit_counter #(.MODULUS(M), .WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(b));
  mod_n_digit_counter #(.MODULUS(M10), .WIDTH(W)) dut10 (
    .clk(clk), .reset_n(reset_n), .bus(b10));

  typedef struct {
    int q;
    bit w;
    int lq;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mq = 0;
  int   ml = 0;
  bit   mw = 1'b0;
  bit   mvalid = 1'b0;
  int   nq = 0;
  bit   nw = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One edge on the MODULUS=6 instance with model prediction.
  task automatic cycle(input bit rn, input bit en, input bit rv, input bit ci,
                       input bit ld, input int lv, input bit lp);
    exp_t e;
    bit   term;
    @(negedge clk);
    reset_n    = rn;
    b.enable   = en;
    b.reverse  = rv;
    b.carry_in = ci;
    b.load     = ld;
    b.load_val = W'(lv);
`ifdef MOD_N_LAP_EN
    b.lap      = lp;
`endif
    b10.enable = 1'b0;
    b10.load   = 1'b0;
    #1;
    term = rv ? (mq == 0) : (mq == M - 1);
    if (mvalid) chk("carry_out", 32'(b.carry_out), 32'(en & ci & ~ld & term));
    if (!rn) begin
      mq = 0; mw = 0; ml = 0; nq = 0; nw = 0; mvalid = 1'b1;
    end else begin
      if (lp) ml = mq;
      if (ld) begin
        mq = (lv > M - 1) ? M - 1 : lv;
        mw = 0;
      end else if (en && ci) begin
        mw = term;
        mq = rv ? (mq + M - 1) % M : (mq + 1) % M;
      end else begin
        mw = 0;
      end
    end
    e.q = mq; e.w = mw; e.lq = ml;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("q", 32'(b.q), 32'(e.q));
    chk("wrapped", 32'(b.wrapped), 32'(e.w));
`ifdef MOD_N_LAP_EN
    chk("lap_q", 32'(b.lap_q), 32'(e.lq));
`endif
  endtask

  // One step edge on the MODULUS=10 instance.
  task automatic cycle10(input bit rv);
    exp_t e;
    bit   term;
    @(negedge clk);
    reset_n      = 1'b1;
    b.enable     = 1'b0;
    b.load       = 1'b0;
`ifdef MOD_N_LAP_EN
    b.lap        = 1'b0;
`endif
    b10.enable   = 1'b1;
    b10.carry_in = 1'b1;
    b10.reverse  = rv;
    b10.load     = 1'b0;
    #1;
    term = rv ? (nq == 0) : (nq == M10 - 1);
    chk("carry_out10", 32'(b10.carry_out), 32'(term));
    nw = term;
    nq = rv ? (nq + M10 - 1) % M10 : (nq + 1) % M10;
    mw = 0;
    e.q = nq; e.w = nw; e.lq = 0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("q10", 32'(b10.q), 32'(e.q));
    chk("wrapped10", 32'(b10.wrapped), 32'(e.w));
  endtask

  initial begin
    reset_n = 1'b0;
    b.enable = 0; b.reverse = 0; b.carry_in = 0; b.load = 0; b.load_val = '0;
    b10.enable = 0; b10.reverse = 0; b10.carry_in = 0; b10.load = 0; b10.load_val = '0;
`ifdef MOD_N_LAP_EN
    b.lap = 0; b10.lap = 0;
`endif
    // reset state
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("q10_reset", 32'(b10.q), 32'(0));
    // reset while stepping from q=4
    cycle(1, 0, 0, 1, 1, 4, 0);
    cycle(0, 1, 0, 1, 0, 0, 0);
    // up count with wrap
    for (int i = 0; i < 7; i++) cycle(1, 1, 0, 1, 0, 0, 0);
    // down from 0, wrap to 5, then back down to 0
    cycle(1, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 1, 1, 1, 0, 0, 0);
    // reverse toggle at q=0 retargets carry_out in the same cycle
    @(negedge clk);
    b.enable = 1; b.carry_in = 1; b.load = 0; b.reverse = 1;
    #1;
    chk("co_at_zero_down", 32'(b.carry_out), 32'(mq == 0));
    b.reverse = 0;
    #1;
    chk("co_after_toggle", 32'(b.carry_out), 32'(mq == M - 1));
    b.enable = 0;
    mw = 0;
    // load clamp and load-over-step priority
    cycle(1, 0, 0, 1, 1, 9, 0);
    cycle(1, 0, 0, 1, 1, 2, 0);
    cycle(1, 1, 0, 1, 1, 3, 0);
    // hold: enable low, then carry_in low
    cycle(1, 0, 0, 1, 1, 5, 0);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, 0, 0, 0);
    // lap capture on the 3->4 step, then reset clears it
    cycle(1, 0, 0, 1, 1, 3, 0);
    cycle(1, 1, 0, 1, 0, 0, 1);
    cycle(1, 1, 0, 1, 0, 0, 0);
    cycle(1, 1, 0, 1, 0, 0, 0);
    cycle(1, 1, 1, 1, 1, 1, 1);
    cycle(0, 1, 0, 1, 0, 0, 0);
    // MODULUS=10 instance: full up cycle and a down wrap
    for (int i = 0; i < 12; i++) cycle10(1'b0);
    for (int i = 0; i < 3; i++) cycle10(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
